// File: rtl/hash_table_arbiter_pkg.sv
// Shared constants for the hash-table arbiter: default sizing, word layout
// and response status bit positions.
package hash_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int KEY_WIDTH_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 26;
  localparam int TAG_DEPTH_DEF  = 4;

  // Request word is {op[1:0], key, data}; the response word has the same width.
  function automatic int calc_w(input int key_width, input int data_width);
    return 2 + data_width + key_width;
  endfunction

  localparam int W_DEF = calc_w(KEY_WIDTH_DEF, DATA_WIDTH_DEF);

  // Status nibble sits at the top of the response word: {status, 2'b00, read_data}.
  localparam int ST_NO_DELETION_TARGET  = DATA_WIDTH_DEF + 2;
  localparam int ST_NO_WRITE_SPACE      = DATA_WIDTH_DEF + 3;
  localparam int ST_NO_ELEMENT_FOUND    = DATA_WIDTH_DEF + 4;
  localparam int ST_KEY_ALREADY_PRESENT = DATA_WIDTH_DEF + 5;

endpackage

// File: rtl/hash_table_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding table
// operation. The head is read combinationally so responses route with no delay.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped here, so a same-cycle pop never frees a slot early.
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign full_o  = (r_count == FULL_COUNT);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// Round-robin arbiter sharing one hash-table port among NUM_REQ requesters,
// with in-order response routing through a tag FIFO.
module hash_table_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_DEPTH  = TAG_DEPTH_DEF,
  localparam int W         = calc_w(KEY_WIDTH, DATA_WIDTH),
  localparam int OW        = $clog2(TAG_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  input  logic [NUM_REQ-1:0]   rsp_ready_i,
  output logic [W-1:0]         rsp_data_o,
  output logic                 tbl_valid_o,
  input  logic                 tbl_ready_i,
  output logic [W-1:0]         tbl_data_o,
  input  logic                 tbl_valid_i,
  output logic                 tbl_ready_o,
  input  logic [W-1:0]         tbl_data_i,
  output logic [OW-1:0]        outstanding_o,
  output logic                 orphan_rsp_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [W-1:0]  w_req_word [NUM_REQ];
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_lock_idx;
  logic          r_lock;
  logic          r_orphan;
  logic [IW-1:0] w_grant;
  logic [IW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign w_req_word[gi] = req_data_i[gi*W +: W];
  end

  // Lowest rotated offset from last_accepted+1 wins; the scan runs downward so it is assigned last.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = r_lock_idx;
    if (!r_lock) begin
      w_grant = r_last;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(r_last) + 1 + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid_i[IW'(idx)]) w_grant = IW'(idx);
      end
    end
  end

  // Outputs are gated by reset so every valid/ready drops asynchronously.
  assign tbl_valid_o = reset & req_valid_i[w_grant] & ~w_full;
  assign tbl_data_o  = w_req_word[w_grant];
  assign w_push      = tbl_valid_o & tbl_ready_i;

  assign tbl_ready_o = reset & (w_empty | rsp_ready_i[w_head]);
  assign w_pop       = tbl_valid_i & tbl_ready_o & ~w_empty;
  assign rsp_data_o  = tbl_data_i;

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[w_grant] = w_push;
    rsp_valid_o          = '0;
    rsp_valid_o[w_head]  = reset & ~w_empty & tbl_valid_i;
  end

  assign orphan_rsp_o = r_orphan;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= IW'(NUM_REQ - 1);
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_orphan   <= 1'b0;
    end else begin
      if (w_push) begin
        r_last <= w_grant;
        r_lock <= 1'b0;
      end else if (tbl_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      if (tbl_valid_i && w_empty) r_orphan <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_grant),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (outstanding_o)
  );

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Bench for hash_table_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model.
module tb_hash_table_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int W  = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i;
  logic [W-1:0]   rsp_data_o;
  logic           tbl_valid_o;
  logic           tbl_ready_i;
  logic [W-1:0]   tbl_data_o;
  logic           tbl_valid_i;
  logic           tbl_ready_o;
  logic [W-1:0]   tbl_data_i;
  logic [2:0]     outstanding_o;
  logic           orphan_rsp_o;

  hash_table_arbiter #(
    .NUM_REQ    (N),
    .KEY_WIDTH  (4),
    .DATA_WIDTH (26),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_data_i    (req_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .tbl_valid_o   (tbl_valid_o),
    .tbl_ready_i   (tbl_ready_i),
    .tbl_data_o    (tbl_data_o),
    .tbl_valid_i   (tbl_valid_i),
    .tbl_ready_o   (tbl_ready_o),
    .tbl_data_i    (tbl_data_i),
    .outstanding_o (outstanding_o),
    .orphan_rsp_o  (orphan_rsp_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: owners of outstanding operations in issue order.
  int q_tags[$];
  int m_last;
  int m_held;
  bit m_orphan;
  int last_push;
  int last_pop;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int got_order[5];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_tags.delete();
    m_last   = N - 1;
    m_held   = -1;
    m_orphan = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_tbl_valid", tbl_valid_o, 0);
    check_eq("rst_req_ready", req_ready_o, 0);
    check_eq("rst_rsp_valid", rsp_valid_o, 0);
    check_eq("rst_tbl_ready", tbl_ready_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_orphan", orphan_rsp_o, 0);
  endtask

  // Entered just after a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    int  g;
    bit  found;
    bit  e_tv;
    bit  e_tr;
    bit  empty;
    bit  full;
    int  head;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_rv;
    bit  push;
    bit  pop;
    #1;
    g = 0;
    found = 1'b0;
    if (m_held >= 0) begin
      g = m_held;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_last + 1 + k) % N;
        if (!found && req_valid_i[idx]) begin
          g = idx;
          found = 1'b1;
        end
      end
    end
    full  = (q_tags.size() == TD);
    empty = (q_tags.size() == 0);
    head  = empty ? 0 : q_tags[0];
    e_tv  = req_valid_i[g] && !full;
    e_rr  = (e_tv && tbl_ready_i) ? N'(1 << g) : '0;
    e_rv  = (!empty && tbl_valid_i) ? N'(1 << head) : '0;
    e_tr  = empty ? 1'b1 : rsp_ready_i[head];
    check_eq("tbl_valid", tbl_valid_o, e_tv);
    check_eq("req_ready", req_ready_o, e_rr);
    if (e_tv) check_eq("tbl_data", tbl_data_o, req_data_i[g*W +: W]);
    check_eq("rsp_valid", rsp_valid_o, e_rv);
    if (e_rv != 0) check_eq("rsp_data", rsp_data_o, tbl_data_i);
    check_eq("tbl_ready", tbl_ready_o, e_tr);
    check_eq("outstanding", outstanding_o, q_tags.size());
    check_eq("orphan", orphan_rsp_o, m_orphan);
    push = e_tv && tbl_ready_i;
    pop  = !empty && tbl_valid_i && rsp_ready_i[head];
    last_push = push ? g : -1;
    last_pop  = pop ? head : -1;
    if (push) $display("cycle %0d: request accepted from requester %0d data %08h", cyc, g, req_data_i[g*W +: W]);
    if (pop)  $display("cycle %0d: response %08h delivered to requester %0d", cyc, tbl_data_i, head);
    if (empty && tbl_valid_i) begin
      m_orphan = 1'b1;
      $display("cycle %0d: orphan response %08h discarded", cyc, tbl_data_i);
    end
    if (pop) void'(q_tags.pop_front());
    if (push) begin
      q_tags.push_back(g);
      m_last = g;
      m_held = -1;
    end else if (e_tv) begin
      m_held = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    tbl_ready_i = 1'b0;
    tbl_valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    reset       = 1'b0;
    req_valid_i = '1;
    for (int i = 0; i < N; i++) req_data_i[i*W +: W] = $urandom;
    rsp_ready_i = '1;
    tbl_ready_i = 1'b1;
    tbl_valid_i = 1'b1;
    tbl_data_i  = $urandom;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);

    // Round robin with all requesters busy and a one-cycle table.
    do_reset();
    req_valid_i = '1;
    rsp_ready_i = '1;
    tbl_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tbl_valid_i = (c > 0);
      tbl_data_i  = $urandom;
      tick();
      got_order[c] = last_push;
      if (c > 0) check_eq("rr_rsp_owner", last_pop, exp_order[c-1]);
    end
    for (int c = 0; c < 5; c++) check_eq("rr_order", got_order[c], exp_order[c]);

    // Grant lock while the table stalls.
    do_reset();
    req_valid_i = 4'b0100;
    tick();
    check_eq("lock_c0", last_push, -1);
    req_valid_i = 4'b0101;
    tick();
    check_eq("lock_c1", last_push, -1);
    tick();
    check_eq("lock_c2", last_push, -1);
    tbl_ready_i = 1'b1;
    tick();
    check_eq("lock_accept2", last_push, 2);
    req_valid_i = 4'b0001;
    tick();
    check_eq("lock_then0", last_push, 0);

    // Fill the tag FIFO with a silent table, then pop and push in one cycle.
    do_reset();
    req_valid_i = '1;
    rsp_ready_i = '1;
    tbl_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_push >= 0) cnt++;
    end
    check_eq("full_accepted", cnt, 4);
    check_eq("full_outstanding", outstanding_o, 4);
    check_eq("full_tbl_valid", tbl_valid_o, 0);
    tbl_valid_i = 1'b1;
    tbl_data_i  = $urandom;
    tick();
    check_eq("nobypass_push", last_push, -1);
    check_eq("nobypass_pop", last_pop, 0);
    check_eq("nobypass_occ3", outstanding_o, 3);
    tbl_valid_i = 1'b0;
    tick();
    check_eq("resume_push", last_push, 0);
    check_eq("resume_occ4", outstanding_o, 4);

    // Orphan response on an idle arbiter.
    do_reset();
    tbl_valid_i = 1'b1;
    tbl_data_i  = $urandom;
    tick();
    tbl_valid_i = 1'b0;
    check_eq("orphan_set", orphan_rsp_o, 1);
    tick();

    // Asynchronous reset with operations outstanding.
    do_reset();
    req_valid_i = '1;
    tbl_ready_i = 1'b1;
    rsp_ready_i = '1;
    for (int c = 0; c < 3; c++) tick();
    check_eq("pre_rst_occ", outstanding_o, 3);
    tbl_valid_i = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tbl_valid_i = 1'b0;
    tick();
    check_eq("post_rst_first", last_push, 0);

    // Randomized traffic; requesters hold valid and data until accepted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tbl_ready_i = ($urandom_range(0, 99) < 70);
      tbl_valid_i = ($urandom_range(0, 99) < 50);
      tbl_data_i  = $urandom;
      rsp_ready_i = N'($urandom);
      tick();
      for (int i = 0; i < N; i++) begin
        if (last_push == i || !req_valid_i[i]) begin
          req_valid_i[i] = ($urandom_range(0, 99) < 55);
          req_data_i[i*W +: W] = $urandom;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hash_table_arbiter.md
HASH_TABLE_ARBITER -- requirements
Module: hash_table_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports; SHALL be 2..8.
REQ-002 Parameter KEY_WIDTH, default 4: key field width.
REQ-003 Parameter DATA_WIDTH, default 26: data field width.
REQ-004 Parameter TAG_DEPTH, default 4: maximum outstanding table operations; SHALL be a power of two, at least 2.
REQ-005 Derived constant W = 2+DATA_WIDTH+KEY_WIDTH (32 by default). Request word is {op[1:0], key, data}; response word is {status[3:0], 2'b00, read_data}.
REQ-006 clk  in  1  sole clock; all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-009 req_ready_o  out  NUM_REQ  per-requester request accepted.
REQ-010 req_data_i  in  NUM_REQ*W  request words; requester i occupies bits [i*W +: W].
REQ-011 rsp_valid_o  out  NUM_REQ  per-requester response valid.
REQ-012 rsp_ready_i  in  NUM_REQ  per-requester response ready.
REQ-013 rsp_data_o  out  W  response word, broadcast to all requesters.
REQ-014 tbl_valid_o / tbl_ready_i / tbl_data_o[W]: request stream to the hash table.
REQ-015 tbl_valid_i / tbl_ready_o / tbl_data_i[W]: response stream from the hash table.
REQ-016 outstanding_o  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy.
REQ-017 orphan_rsp_o  out  1  sticky flag: a table response arrived while no request was outstanding.

Function
REQ-018 Arbitration SHALL be round-robin. Priority starts at requester (last_accepted+1) mod NUM_REQ. After reset, requester 0 has highest priority.
REQ-019 Request path combinational: tbl_valid_o = granted requester valid AND tag FIFO not full. tbl_data_o = granted requester's word.
REQ-020 req_ready_o[g] = tbl_ready_i AND tag FIFO not full, for the granted g only. All other req_ready_o bits are 0.
REQ-021 Grant lock: if tbl_valid_o=1 and tbl_ready_i=0, the grant SHALL be held until the handshake, whatever other requesters do. Lock state is a registered flag plus a registered index.
REQ-022 On each request handshake, the granted index is pushed into the tag FIFO and becomes last_accepted. The lock clears.
REQ-023 Responses are in order. When the FIFO is non-empty: rsp_valid_o[head] = tbl_valid_i, rsp_data_o = tbl_data_i, tbl_ready_o = rsp_ready_i[head]. All other rsp_valid_o bits are 0.
REQ-024 On each response handshake, the FIFO head is popped.
REQ-025 Full FIFO: no request is accepted, even if a pop occurs in the same cycle (no bypass). Acceptance resumes the following cycle.
REQ-026 Empty FIFO with tbl_valid_i=1: tbl_ready_o=1 (response discarded), orphan_rsp_o set to 1 until reset, and no rsp_valid_o asserted.
REQ-027 Simultaneous push and pop on a non-full FIFO: occupancy unchanged, both pointers advance, wrap modulo TAG_DEPTH.
REQ-028 Latency: zero added cycles on either path. A requester's request and response may both complete in the same cycle if the table does so.
REQ-029 Requesters SHALL hold valid and data stable until ready. The arbiter does not check this.

Reset
REQ-030 While reset=0: all valid and ready outputs are 0, outstanding_o=0, orphan_rsp_o=0, the FIFO is empty, the lock is clear, and last_accepted=NUM_REQ-1.
REQ-031 Reset mid-operation abandons all outstanding tags. Responses arriving after release are treated as orphans (REQ-026).

Structure
REQ-032 Package hash_arb_pkg SHALL hold: the W derivation, status bit positions (28 no_deletion_target, 29 no_write_space, 30 no_element_found, 31 key_already_present, all relative to DATA_WIDTH=26 layout), and the default parameters.
REQ-033 Sub-module tag_fifo (depth TAG_DEPTH, width $clog2(NUM_REQ), with full, empty and count outputs). Arbitration and lock logic stay in the top module.

Verification
REQ-034 Requesters 0..3 all valid, tbl_ready_i=1 constantly, table responds one cycle later -> grants in order 0,1,2,3,0; each response is routed to its originator.
REQ-035 Requester 2 valid, tbl_ready_i=0 for 3 cycles, requester 0 raises valid in cycle 1 -> grant stays on 2; requester 2 is accepted in cycle 3 and requester 0 next.
REQ-036 TAG_DEPTH=4, table never responds, 6 requests offered -> exactly 4 accepted, outstanding_o=4, tbl_valid_o=0 afterwards.
REQ-037 FIFO full, response handshake and a pending request in the same cycle -> request not accepted that cycle, accepted the next; outstanding_o goes 4,3,4.
REQ-038 tbl_valid_i=1 after reset with no request -> tbl_ready_o=1, orphan_rsp_o=1 from the next cycle, no rsp_valid_o.
REQ-039 reset pulsed low with 3 outstanding -> outstanding_o=0 and all outputs at REQ-030 values asynchronously; normal operation from requester 0 after release.
